op_log_reader: RTL



---
 rtl/timer_pkg.sv | 26 ++
 rtl/op_log_if.sv | 33 +++
 rtl/mod_depth_ptr.sv | 33 +++
 rtl/op_log_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the stopwatch timer operation log: op codes,
// log geometry and the reader FSM state encoding.
package timer_pkg;

  // Operation codes written into the log by the time-manager.
  localparam logic [2:0] OP_IDLE  = 3'b000;
  localparam logic [2:0] OP_START = 3'b001;
  localparam logic [2:0] OP_STOP  = 3'b010;
  localparam logic [2:0] OP_RESET = 3'b100;

  // Log geometry shared with the writer.
  localparam int LOG_DEPTH = 10;
  localparam int LOG_AW    = 10;
  localparam int OP_W      = 3;
  // Width of a slot index / entry count (holds 0..LOG_DEPTH).
  localparam int IDX_W     = 4;

  // Reader FSM states.
  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_READ    = 2'd1,
    RD_WAIT    = 2'd2,
    RD_PRESENT = 2'd3
  } rd_state_e;

endpackage

// File: rtl/op_log_if.sv
// Bus between the log reader, the log memory read port and the downstream
// formatter.
//
// Handshake: the output stream is strict valid/ready. An entry transfers on
// a rising clk edge where out_valid and out_ready are both 1. Once out_valid
// is raised, out_valid, out_op and out_last stay stable until that transfer.
// out_ready may change freely and never depends combinationally on out_valid.
// The memory read port has no handshake: mem_rdata is valid exactly one cycle
// after a cycle with mem_re=1.
interface op_log_if #(
  parameter int AW  = timer_pkg::LOG_AW,
  parameter int OPW = timer_pkg::OP_W
);
  logic           mem_re;
  logic [AW-1:0]  mem_addr;
  logic [OPW-1:0] mem_rdata;
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] out_op;
  logic           out_last;

  // Reader side.
  modport master (
    output mem_re, mem_addr, out_valid, out_op, out_last,
    input  mem_rdata, out_ready
  );

  // Memory / downstream side.
  modport slave (
    input  mem_re, mem_addr, out_valid, out_op, out_last,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/mod_depth_ptr.sv
// Modulo-DEPTH pointer arithmetic: res = (a + inc - b) mod DEPTH.
// With b=0, inc=1 it is the wrapping increment; with inc=0 it is a
// subtract-with-wrap. a is in 0..DEPTH-1, b in 0..DEPTH; the sum is formed
// first so no intermediate goes negative.
module mod_depth_ptr #(
  parameter int DEPTH = 10,
  parameter int IW    = 4
) (
  input  logic [IW-1:0] a,
  input  logic [IW-1:0] b,
  input  logic          inc,
  output logic [IW-1:0] res
);
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

  logic [IW:0] sum;
  logic [IW:0] diff;

  // Add the increment, subtract with wrap, then fold a result of DEPTH to 0.
  always_comb begin
    sum  = {1'b0, a} + {{IW{1'b0}}, inc};
    diff = '0;
    if (sum >= {1'b0, b}) begin
      diff = sum - {1'b0, b};
    end else begin
      diff = sum + DEPTH_W - {1'b0, b};
    end
    if (diff >= DEPTH_W) begin
      diff = diff - DEPTH_W;
    end
    res = diff[IW-1:0];
  end
endmodule

// File: rtl/op_log_reader.sv
// Read side of the circular operation log. Tracks the writer to know where
// the newest entry is and how many are valid, and on rd_req streams a
// snapshot of the log oldest-to-newest over a valid/ready interface.
module op_log_reader
  import timer_pkg::*;
#(
  parameter int DEPTH = LOG_DEPTH,
  parameter int AW    = LOG_AW,
  parameter int OPW   = OP_W
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          wr_we,
  input  logic [AW-1:0] wr_addr,
  input  logic          rd_req,
  input  logic          clr,
  op_log_if.master      bus,
  output logic          busy,
  output logic          overrun,
  output logic [3:0]    count,
  output rd_state_e     state_dbg
);
  localparam int IW = IDX_W;
  localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  rd_state_e      state_q, state_d;
  logic [IW-1:0]  last_slot_q, last_slot_d;
  logic [IW-1:0]  count_q, count_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  remaining_q, remaining_d;
  logic           clr_pend_q, clr_pend_d;
  logic           mem_re_q, mem_re_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic           out_valid_q, out_valid_d;
  logic [OPW-1:0] out_op_q, out_op_d;
  logic           out_last_q, out_last_d;
  logic           busy_q, busy_d;
  logic           overrun_q, overrun_d;

  logic [IW-1:0]  wr_slot;
  logic           wr_in_range;
  logic [IW-1:0]  oldest_ptr;
  logic [IW-1:0]  ptr_next;
  logic [IW-1:0]  wr_dist;
  logic           dump_done;
  logic           clr_now;

  assign wr_slot     = wr_addr[IW-1:0];
  assign wr_in_range = (wr_addr < DEPTH_A);

  // Oldest valid slot: last_slot + 1 - count.
  mod_depth_ptr #(.DEPTH(DEPTH), .IW(IW)) u_oldest (
    .a   (last_slot_q),
    .b   (count_q),
    .inc (1'b1),
    .res (oldest_ptr)
  );

  // Read pointer advance after each handshake.
  mod_depth_ptr #(.DEPTH(DEPTH), .IW(IW)) u_advance (
    .a   (ptr_q),
    .b   ({IW{1'b0}}),
    .inc (1'b1),
    .res (ptr_next)
  );

  // Distance of the slot being written ahead of the read pointer; slots with
  // distance below 'remaining' are still owed to the downstream.
  mod_depth_ptr #(.DEPTH(DEPTH), .IW(IW)) u_wr_dist (
    .a   (wr_slot),
    .b   (ptr_q),
    .inc (1'b0),
    .res (wr_dist)
  );

  assign dump_done = (state_q == RD_PRESENT) && bus.out_ready && (remaining_q == 1);

  // Next-state logic: log tracking, deferred clear, overrun and the dump FSM.
  always_comb begin
    state_d     = state_q;
    last_slot_d = last_slot_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    clr_pend_d  = clr_pend_q;
    mem_re_d    = mem_re_q;
    mem_addr_d  = mem_addr_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q;

    // Follow the writer regardless of the dump.
    if (wr_we) begin
      last_slot_d = wr_slot;
      if (count_q < DEPTH_I) begin
        count_d = count_q + 1'b1;
      end
    end

    // A clear during a dump is remembered and applied as the dump ends, so
    // the snapshot being streamed stays consistent with count.
    if (clr && busy_q) begin
      clr_pend_d = 1'b1;
    end
    if (dump_done) begin
      clr_pend_d = 1'b0;
    end
    clr_now = (clr && !busy_q) || (dump_done && (clr_pend_q || clr));
    if (clr_now) begin
      count_d = wr_we ? {{(IW-1){1'b0}}, 1'b1} : '0;
    end

    // Flag writes that land on a slot not yet handed downstream. In PRESENT
    // the current slot is already captured, so only later slots count.
    if (busy_q && wr_we && wr_in_range) begin
      if (state_q == RD_PRESENT) begin
        if ((wr_dist != '0) && (wr_dist < remaining_q)) begin
          overrun_d = 1'b1;
        end
      end else if (wr_dist < remaining_q) begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      RD_IDLE: begin
        if (rd_req && (count_q != '0)) begin
          state_d     = RD_READ;
          ptr_d       = oldest_ptr;
          remaining_d = count_q;
          overrun_d   = 1'b0;
          mem_re_d    = 1'b1;
          mem_addr_d  = {{(AW-IW){1'b0}}, oldest_ptr};
          busy_d      = 1'b1;
        end
      end
      RD_READ: begin
        mem_re_d = 1'b0;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        out_op_d    = bus.mem_rdata;
        out_last_d  = (remaining_q == 1);
        out_valid_d = 1'b1;
        state_d     = RD_PRESENT;
      end
      RD_PRESENT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          remaining_d = remaining_q - 1'b1;
          ptr_d       = ptr_next;
          if (remaining_q == 1) begin
            state_d = RD_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d    = RD_READ;
            mem_re_d   = 1'b1;
            mem_addr_d = {{(AW-IW){1'b0}}, ptr_next};
          end
        end
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= RD_IDLE;
      last_slot_q <= DEPTH_I - 1'b1;
      count_q     <= '0;
      ptr_q       <= '0;
      remaining_q <= '0;
      clr_pend_q  <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_slot_q <= last_slot_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      clr_pend_q  <= clr_pend_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.mem_re    = mem_re_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_op    = out_op_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;
  assign count         = count_q;
  assign state_dbg     = state_q;

endmodule
